// File: rtl/shiftreg_seq_if.sv
// Upstream word handshake and downstream shift-register control bundle
// for shiftreg_seq. The slave modport is the sequencer's view of the bundle.
// The master modport is the view of whatever drives words in and watches the strobes.
interface shiftreg_seq_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic             pload_out;
    logic [WIDTH-1:0] pdata_out;
    logic             shift_out;
    logic             busy_out;
    logic             word_done_out;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  pload_out,
        input  pdata_out,
        input  shift_out,
        input  busy_out,
        input  word_done_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output pload_out,
        output pdata_out,
        output shift_out,
        output busy_out,
        output word_done_out
    );
endinterface

// File: rtl/shiftreg_seq.sv
// shiftreg_seq: sequences parallel words into an external shift register.
// A one-entry holding buffer accepts a word from upstream. The FSM then
// issues one parallel-load strobe, followed by WIDTH shift strobes spaced
// DIV cycles apart. An optional idle gap of GAP bit periods follows each word.
// Every output is driven straight from a flop.
module shiftreg_seq #(
    parameter int WIDTH = 10,
    parameter int DIV   = 4,
    parameter int GAP   = 0
) (
    input  logic          clock_in,
    input  logic          reset_in,
    shiftreg_seq_if.slave bus
);

    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W   = $clog2(WIDTH + 1);
    localparam int GAP_CYC = GAP * DIV;
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state_q, state_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             ready_q, ready_d;
    logic             pload_q, pload_d;
    logic [WIDTH-1:0] pdata_q, pdata_d;
    logic             shift_q, shift_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [BIT_W-1:0] bits_q, bits_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic             accept;
    logic             word_avail;
    logic [WIDTH-1:0] next_word;
    logic             do_load;

    // A word taken at the same edge the FSM becomes free is forwarded
    // straight into LOAD, so the load strobe is not delayed by a cycle.
    assign accept     = bus.valid_in && ready_q;
    assign word_avail = full_q || accept;
    assign next_word  = full_q ? hold_q : bus.data_in;

    // Next-state, counter and registered-output decode for the sequencer.
    always_comb begin
        state_d = state_q;
        full_d  = full_q;
        hold_d  = hold_q;
        pdata_d = pdata_q;
        pload_d = 1'b0;
        shift_d = 1'b0;
        done_d  = 1'b0;
        phase_d = phase_q;
        bits_d  = bits_q;
        gap_d   = gap_q;
        do_load = 1'b0;

        if (accept) begin
            full_d = 1'b1;
            hold_d = bus.data_in;
        end

        if (state_q == ST_LOAD) begin
            full_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                do_load = word_avail;
            end

            ST_LOAD, ST_SHIFT: begin
                if (state_q == ST_SHIFT && done_q) begin
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LAST;
                    end else if (word_avail) begin
                        do_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_SHIFT;
                    if (phase_q == DIV_LAST) begin
                        phase_d = '0;
                        shift_d = 1'b1;
                        bits_d  = bits_q + BIT_W'(1);
                        done_d  = (bits_q == BIT_LAST);
                    end else begin
                        phase_d = phase_q + DIV_W'(1);
                    end
                end
            end

            ST_GAP: begin
                if (gap_q == '0) begin
                    if (word_avail) begin
                        do_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_load) begin
            state_d = ST_LOAD;
            pload_d = 1'b1;
            pdata_d = next_word;
            phase_d = '0;
            bits_d  = '0;
        end

        busy_d  = (state_d != ST_IDLE);
        ready_d = !full_d;
    end

    // State, buffer, counters and outputs; reset drops any word in flight.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            full_q  <= 1'b0;
            hold_q  <= '0;
            ready_q <= 1'b0;
            pload_q <= 1'b0;
            pdata_q <= '0;
            shift_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            phase_q <= '0;
            bits_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            hold_q  <= hold_d;
            ready_q <= ready_d;
            pload_q <= pload_d;
            pdata_q <= pdata_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            phase_q <= phase_d;
            bits_q  <= bits_d;
            gap_q   <= gap_d;
        end
    end

    assign bus.ready_out     = ready_q;
    assign bus.pload_out     = pload_q;
    assign bus.pdata_out     = pdata_q;
    assign bus.shift_out     = shift_q;
    assign bus.busy_out      = busy_q;
    assign bus.word_done_out = done_q;

endmodule

// File: tb/tb_shiftreg_seq.sv
// Testbench for shiftreg_seq. Three configurations share the same input stream:
// (DIV=4, GAP=0), (DIV=4, GAP=2) and (DIV=1, GAP=0), all with WIDTH=10.
// The reference model works from word schedules rather than per-cycle state.
// Each accepted word is given a load cycle. The shift, done and busy cycles
// follow from the load cycle by arithmetic.
module tb_shiftreg_seq;

    localparam int WIDTH = 10;
    localparam int MAXC  = 4096;
    localparam int NCFG  = 3;

    logic             clk = 1'b0;
    logic             drv_rst = 1'b1;
    logic             drv_valid = 1'b0;
    logic [WIDTH-1:0] drv_data = '0;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    bit               in_rst  [MAXC];
    bit               m_occ   [NCFG][MAXC];
    bit               m_pload [NCFG][MAXC];
    bit               m_shift [NCFG][MAXC];
    bit               m_done  [NCFG][MAXC];
    bit               m_busy  [NCFG][MAXC];
    logic [WIDTH-1:0] m_word  [NCFG][MAXC];
    int               m_free  [NCFG];
    logic [WIDTH-1:0] cur_pdata [NCFG];

    int cnt_shift [NCFG];
    int cnt_pload [NCFG];
    int cnt_done  [NCFG];

    logic [NCFG-1:0]  obs_ready, obs_pload, obs_shift, obs_busy, obs_done;
    logic [WIDTH-1:0] obs_pdata [NCFG];

    shiftreg_seq_if #(.WIDTH(WIDTH)) bus_a ();
    shiftreg_seq_if #(.WIDTH(WIDTH)) bus_g ();
    shiftreg_seq_if #(.WIDTH(WIDTH)) bus_d ();

    shiftreg_seq #(.WIDTH(WIDTH), .DIV(4), .GAP(0)) dut_a (
        .clock_in (clk),
        .reset_in (drv_rst),
        .bus      (bus_a)
    );

    shiftreg_seq #(.WIDTH(WIDTH), .DIV(4), .GAP(2)) dut_g (
        .clock_in (clk),
        .reset_in (drv_rst),
        .bus      (bus_g)
    );

    shiftreg_seq #(.WIDTH(WIDTH), .DIV(1), .GAP(0)) dut_d (
        .clock_in (clk),
        .reset_in (drv_rst),
        .bus      (bus_d)
    );

    assign bus_a.data_in  = drv_data;
    assign bus_a.valid_in = drv_valid;
    assign bus_g.data_in  = drv_data;
    assign bus_g.valid_in = drv_valid;
    assign bus_d.data_in  = drv_data;
    assign bus_d.valid_in = drv_valid;

    assign obs_ready = {bus_d.ready_out, bus_g.ready_out, bus_a.ready_out};
    assign obs_pload = {bus_d.pload_out, bus_g.pload_out, bus_a.pload_out};
    assign obs_shift = {bus_d.shift_out, bus_g.shift_out, bus_a.shift_out};
    assign obs_busy  = {bus_d.busy_out, bus_g.busy_out, bus_a.busy_out};
    assign obs_done  = {bus_d.word_done_out, bus_g.word_done_out, bus_a.word_done_out};
    assign obs_pdata[0] = bus_a.pdata_out;
    assign obs_pdata[1] = bus_g.pdata_out;
    assign obs_pdata[2] = bus_d.pdata_out;

    // Free-running clock; rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    function automatic int cfg_div(input int c);
        return (c == 2) ? 1 : 4;
    endfunction

    function automatic int cfg_gap(input int c);
        return (c == 1) ? 2 : 0;
    endfunction

    // The buffer is free when the block is out of reset and holds no word.
    function automatic bit exp_ready(input int c, input int n);
        return !in_rst[n] && !m_occ[c][n];
    endfunction

    task automatic check_output(input string tag, input int c, input logic [31:0] obs,
                                input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s cfg%0d cycle %0d: observed %0h expected %0h",
                   tag, c, cyc, obs, exp);
        end
    endtask

    // Place a word accepted at edge a into configuration c's schedule.
    task automatic schedule_word(input int c, input int a, input logic [WIDTH-1:0] d);
        int ld;
        int span;
        int tail;
        ld   = (a > m_free[c]) ? a : m_free[c];
        span = WIDTH * cfg_div(c);
        tail = ld + span + cfg_gap(c) * cfg_div(c);
        for (int k = a; k <= ld; k++) if (k < MAXC) m_occ[c][k] = 1'b1;
        if (ld < MAXC) begin
            m_pload[c][ld] = 1'b1;
            m_word[c][ld]  = d;
        end
        for (int b = 1; b <= WIDTH; b++) begin
            if (ld + b * cfg_div(c) < MAXC) m_shift[c][ld + b * cfg_div(c)] = 1'b1;
        end
        if (ld + span < MAXC) m_done[c][ld + span] = 1'b1;
        for (int k = ld; k <= tail; k++) if (k < MAXC) m_busy[c][k] = 1'b1;
        m_free[c] = tail + 1;
    endtask

    // A reset at edge r wipes every scheduled event from r onward.
    task automatic model_reset(input int r);
        in_rst[r] = 1'b1;
        for (int c = 0; c < NCFG; c++) begin
            for (int k = r; k < MAXC; k++) begin
                m_occ[c][k]   = 1'b0;
                m_pload[c][k] = 1'b0;
                m_shift[c][k] = 1'b0;
                m_done[c][k]  = 1'b0;
                m_busy[c][k]  = 1'b0;
            end
            m_free[c] = 0;
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < NCFG; c++) begin
            cnt_shift[c] = 0;
            cnt_pload[c] = 0;
            cnt_done[c]  = 0;
        end
    endtask

    // One cycle: check the current outputs at the falling edge, then
    // update the model and drive the inputs for the next rising edge.
    task automatic apply_stimulus(input bit rst, input bit v, input logic [WIDTH-1:0] d);
        int n;
        n = cyc;
        if (n >= 1) begin
            for (int c = 0; c < NCFG; c++) begin
                if (in_rst[n]) cur_pdata[c] = '0;
                else if (m_pload[c][n]) cur_pdata[c] = m_word[c][n];
                check_output("ready", c, 32'(obs_ready[c]), 32'(exp_ready(c, n)));
                check_output("pload", c, 32'(obs_pload[c]), 32'(m_pload[c][n]));
                check_output("pdata", c, 32'(obs_pdata[c]), 32'(cur_pdata[c]));
                check_output("shift", c, 32'(obs_shift[c]), 32'(m_shift[c][n]));
                check_output("done", c, 32'(obs_done[c]), 32'(m_done[c][n]));
                check_output("busy", c, 32'(obs_busy[c]), 32'(m_busy[c][n]));
                check_output("overlap", c, 32'(obs_pload[c] & obs_shift[c]), 32'd0);
                if (obs_shift[c] === 1'b1) cnt_shift[c]++;
                if (obs_pload[c] === 1'b1) cnt_pload[c]++;
                if (obs_done[c] === 1'b1) cnt_done[c]++;
            end
        end
        if (rst) begin
            model_reset(n + 1);
        end else if (v) begin
            for (int c = 0; c < NCFG; c++) begin
                if (exp_ready(c, n)) schedule_word(c, n + 1, d);
            end
        end
        drv_rst   = rst;
        drv_valid = v;
        drv_data  = d;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        $display("[TB] shiftreg_seq bench start");
        for (int c = 0; c < NCFG; c++) begin
            m_free[c]    = 0;
            cur_pdata[c] = '0;
        end
        clear_counts();

        // Reset for two edges, then release with nothing offered.
        apply_stimulus(1'b1, 1'b0, '0);
        apply_stimulus(1'b1, 1'b0, '0);
        repeat (3) apply_stimulus(1'b0, 1'b0, '0);

        // Single word 0x2A5: one load, ten shifts, one done pulse per config.
        clear_counts();
        apply_stimulus(1'b0, 1'b1, 10'h2A5);
        repeat (60) apply_stimulus(1'b0, 1'b0, '0);
        for (int c = 0; c < NCFG; c++) begin
            check_output("single_shift_count", c, 32'(cnt_shift[c]), 32'd10);
            check_output("single_pload_count", c, 32'(cnt_pload[c]), 32'd1);
            check_output("single_done_count", c, 32'(cnt_done[c]), 32'd1);
        end

        // Back-to-back: 0x155, then 0x0AA held until the buffer frees up.
        clear_counts();
        apply_stimulus(1'b0, 1'b1, 10'h155);
        apply_stimulus(1'b0, 1'b1, 10'h0AA);
        apply_stimulus(1'b0, 1'b1, 10'h0AA);
        repeat (110) apply_stimulus(1'b0, 1'b0, '0);
        for (int c = 0; c < NCFG; c++) begin
            check_output("b2b_pload_count", c, 32'(cnt_pload[c]), 32'd2);
            check_output("b2b_shift_count", c, 32'(cnt_shift[c]), 32'd20);
        end

        // Backpressure: valid held high with fresh random data every cycle.
        repeat (300) apply_stimulus(1'b0, 1'b1, WIDTH'($urandom));
        repeat (120) apply_stimulus(1'b0, 1'b0, '0);

        // Random traffic.
        repeat (800) apply_stimulus(1'b0, 1'($urandom_range(0, 1)), WIDTH'($urandom));
        repeat (120) apply_stimulus(1'b0, 1'b0, '0);

        // Reset after the third shift of a word; nothing may follow it.
        clear_counts();
        apply_stimulus(1'b0, 1'b1, 10'h3C3);
        repeat (13) apply_stimulus(1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 1'b0, '0);
        apply_stimulus(1'b1, 1'b0, '0);
        check_output("pre_reset_shifts", 0, 32'(cnt_shift[0]), 32'd3);
        clear_counts();
        repeat (60) apply_stimulus(1'b0, 1'b0, '0);
        for (int c = 0; c < NCFG; c++) begin
            check_output("post_reset_shifts", c, 32'(cnt_shift[c]), 32'd0);
            check_output("post_reset_ploads", c, 32'(cnt_pload[c]), 32'd0);
        end

        // A short burst after the reset shows the block still works.
        repeat (200) apply_stimulus(1'b0, 1'($urandom_range(0, 1)), WIDTH'($urandom));
        repeat (10) apply_stimulus(1'b0, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
